// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder (4-bit groups, second-level group lookahead) with valid/ready flow control.
// Define CLA_OVF_EN to add the registered two's-complement overflow output ovf.
module cla_adder_pipe #(
   parameter int WIDTH = 16,
   localparam int GROUPS = WIDTH / 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             g_all,
   output logic             p_all
`ifdef CLA_OVF_EN
   ,
   output logic             ovf
`endif
);

   function automatic logic grp_gen(input logic [3:0] g, input logic [3:0] p);
      return g[3] | (g[2] & p[3]) | (g[1] & p[2] & p[3]) | (g[0] & p[1] & p[2] & p[3]);
   endfunction

   logic              s1_adv, s2_adv, ld_p1, ld_p2;
   logic              vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
   logic [WIDTH-1:0]  a_p1_q, a_p1_d, b_p1_q, b_p1_d, x_p1_q, x_p1_d;
   logic              cin_p1_q, cin_p1_d;
   logic [GROUPS-1:0] gg_p1_q, gg_p1_d, gp_p1_q, gp_p1_d;
   logic [WIDTH-1:0]  bg, bp;
   logic [GROUPS:0]   cg;
   logic [WIDTH:0]    c;
   logic              gw, acc, pr;
   logic [WIDTH-1:0]  sum_p2_q, sum_p2_d;
   logic              cout_p2_q, cout_p2_d, gall_p2_q, gall_p2_d, pall_p2_q, pall_p2_d;
   logic              ovf_p2_q, ovf_p2_d;

   // Flow control: a stage advances when its downstream slot is empty or draining
   always_comb begin
      s2_adv   = !vld_p2_q || out_ready;
      s1_adv   = !vld_p1_q || s2_adv;
      ld_p1    = s1_adv && in_valid;
      ld_p2    = s2_adv && vld_p1_q;
      vld_p1_d = s1_adv ? in_valid : vld_p1_q;
      vld_p2_d = s2_adv ? vld_p1_q : vld_p2_q;
   end

   // ---- Stage 1: operands, bitwise propagate-sum and per-group G/P ----
   always_comb begin
      a_p1_d   = a_p1_q;
      b_p1_d   = b_p1_q;
      x_p1_d   = x_p1_q;
      cin_p1_d = cin_p1_q;
      gg_p1_d  = gg_p1_q;
      gp_p1_d  = gp_p1_q;
      if (ld_p1) begin
         a_p1_d   = a;
         b_p1_d   = b;
         x_p1_d   = a ^ b;
         cin_p1_d = c_in;
         for (int j = 0; j < GROUPS; j++) begin
            gg_p1_d[j] = grp_gen(a[4*j +: 4] & b[4*j +: 4], a[4*j +: 4] | b[4*j +: 4]);
            gp_p1_d[j] = &(a[4*j +: 4] | b[4*j +: 4]);
         end
      end
   end

   // ---- Stage 2: flat group lookahead, in-group carries, sum ----
   always_comb begin
      bg    = a_p1_q & b_p1_q;
      bp    = a_p1_q | b_p1_q;
      cg    = '0;
      c     = '0;
      gw    = 1'b0;
      acc   = 1'b0;
      pr    = 1'b1;
      cg[0] = cin_p1_q;
      // Each group carry is a sum of products over all lower groups, no ripple
      for (int j = 0; j < GROUPS; j++) begin
         acc = 1'b0;
         pr  = 1'b1;
         for (int k = j; k >= 0; k--) begin
            acc = acc | (gg_p1_q[k] & pr);
            pr  = pr & gp_p1_q[k];
         end
         cg[j+1] = acc | (pr & cin_p1_q);
         if (j == GROUPS - 1) gw = acc;
      end
      for (int j = 0; j < GROUPS; j++) begin
         for (int i = 0; i < 4; i++) begin
            acc = 1'b0;
            pr  = 1'b1;
            for (int k = i - 1; k >= 0; k--) begin
               acc = acc | (bg[4*j+k] & pr);
               pr  = pr & bp[4*j+k];
            end
            c[4*j+i] = acc | (pr & cg[j]);
         end
      end
      c[WIDTH] = cg[GROUPS];
   end

   always_comb begin
      sum_p2_d  = sum_p2_q;
      cout_p2_d = cout_p2_q;
      gall_p2_d = gall_p2_q;
      pall_p2_d = pall_p2_q;
      ovf_p2_d  = ovf_p2_q;
      if (ld_p2) begin
         sum_p2_d  = x_p1_q ^ c[WIDTH-1:0];
         cout_p2_d = c[WIDTH];
         gall_p2_d = gw;
         pall_p2_d = &gp_p1_q;
`ifdef CLA_OVF_EN
         ovf_p2_d  = c[WIDTH-1] ^ c[WIDTH];
`else
         ovf_p2_d  = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      a_p1_q   <= a_p1_d;
      b_p1_q   <= b_p1_d;
      x_p1_q   <= x_p1_d;
      cin_p1_q <= cin_p1_d;
      gg_p1_q  <= gg_p1_d;
      gp_p1_q  <= gp_p1_d;
   end

   // Result registers are cleared by reset so no stale data is visible afterwards
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1_q  <= 1'b0;
         vld_p2_q  <= 1'b0;
         sum_p2_q  <= '0;
         cout_p2_q <= 1'b0;
         gall_p2_q <= 1'b0;
         pall_p2_q <= 1'b0;
         ovf_p2_q  <= 1'b0;
      end else begin
         vld_p1_q  <= vld_p1_d;
         vld_p2_q  <= vld_p2_d;
         sum_p2_q  <= sum_p2_d;
         cout_p2_q <= cout_p2_d;
         gall_p2_q <= gall_p2_d;
         pall_p2_q <= pall_p2_d;
         ovf_p2_q  <= ovf_p2_d;
      end
   end

   assign in_ready  = s1_adv;
   assign out_valid = vld_p2_q;
   assign sum       = sum_p2_q;
   assign c_out     = cout_p2_q;
   assign g_all     = gall_p2_q;
   assign p_all     = pall_p2_q;
`ifdef CLA_OVF_EN
   assign ovf       = ovf_p2_q;
`else
   logic unused_ovf;
   assign unused_ovf = ovf_p2_q;
`endif

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Bench for cla_adder_pipe: WIDTH=4, 16 and 64 instances driven in lockstep; directed table plus handshake corner sequences and random traffic.
module tb_cla_adder_pipe;

   typedef struct {
      logic [15:0] a, b;
      logic        cin;
      logic [15:0] s;
      logic        c, g, p, o;
   } vec_t;

   typedef struct {
      logic [15:0] s16;
      logic        c16, g16, p16, o16;
      logic [4:0]  r4;
      logic [64:0] r64;
   } sb_t;

   logic        clk, rst, in_valid, out_ready, c_in;
   logic [63:0] a64, b64;
   logic        rdy4, ov4, c4, g4, p4;
   logic [3:0]  s4;
   logic        rdy16, ov16, c16, g16, p16;
   logic [15:0] s16;
   logic        rdy64, ov64, c64, g64, p64;
   logic [63:0] s64;
`ifdef CLA_OVF_EN
   logic        o4, o16, o64;
`endif

   int   chk, err;
   sb_t  sbq[$];
   sb_t  cur;
   logic ov_s, rdy_s;
   vec_t tbl[10];

   cla_adder_pipe #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .a(a64[3:0]), .b(b64[3:0]),
      .c_in(c_in), .out_valid(ov4), .out_ready(out_ready), .sum(s4), .c_out(c4), .g_all(g4), .p_all(p4)
`ifdef CLA_OVF_EN
      , .ovf(o4)
`endif
   );
   cla_adder_pipe #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16), .a(a64[15:0]), .b(b64[15:0]),
      .c_in(c_in), .out_valid(ov16), .out_ready(out_ready), .sum(s16), .c_out(c16), .g_all(g16), .p_all(p16)
`ifdef CLA_OVF_EN
      , .ovf(o16)
`endif
   );
   cla_adder_pipe #(.WIDTH(64)) dut64 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64), .a(a64), .b(b64),
      .c_in(c_in), .out_valid(ov64), .out_ready(out_ready), .sum(s64), .c_out(c64), .g_all(g64), .p_all(p64)
`ifdef CLA_OVF_EN
      , .ovf(o64)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      chk++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Expected values for the 4- and 64-bit instances, plus 16-bit fields supplied by caller
   function automatic sb_t mk(input logic [63:0] a, input logic [63:0] b, input logic ci,
                              input logic [15:0] s, input logic c, input logic g, input logic p, input logic o);
      sb_t e;
      e.s16 = s; e.c16 = c; e.g16 = g; e.p16 = p; e.o16 = o;
      e.r4  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, ci};
      e.r64 = {1'b0, a} + {1'b0, b} + {64'b0, ci};
      return e;
   endfunction

   function automatic sb_t model(input logic [63:0] a, input logic [63:0] b, input logic ci);
      logic [16:0] r, rg;
      logic        o;
      r  = {1'b0, a[15:0]} + {1'b0, b[15:0]} + {16'b0, ci};
      rg = {1'b0, a[15:0]} + {1'b0, b[15:0]};
      o  = (a[15] == b[15]) && (r[15] != a[15]);
      return mk(a, b, ci, r[15:0], r[16], rg[16], &(a[15:0] | b[15:0]), o);
   endfunction

   task automatic drive_vec(input vec_t v);
      a64 = {48'h0, v.a};
      b64 = {48'h0, v.b};
      c_in = v.cin;
      cur = mk(a64, b64, v.cin, v.s, v.c, v.g, v.p, v.o);
   endtask

   task automatic tick();
      sb_t e;
      @(negedge clk);
      ov_s  = ov16;
      rdy_s = rdy16;
      if (ov16 && out_ready) begin
         if (sbq.size() == 0) begin
            chk++; err++;
            $display("FAIL spurious_out: got sum=%0h with no result expected", s16);
         end else begin
            e = sbq.pop_front();
            check("w16_sum_cout", {c16, s16}, {e.c16, e.s16});
            check("w16_g_p", {g16, p16}, {e.g16, e.p16});
`ifdef CLA_OVF_EN
            check("w16_ovf", o16, e.o16);
`endif
            check("w4_res", {ov4, c4, s4}, {1'b1, e.r4});
            check("w64_res", {ov64, c64, s64}, {1'b1, e.r64});
         end
      end
      if (in_valid && rdy16) sbq.push_back(cur);
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int n);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      logic [4:0]  vbits;
      logic [11:0] iv, ovb, expb;
      logic [15:0] hold2, hold3, ba, bb;
      int          k, stale;
      chk = 0; err = 0;
      tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[5] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[6] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[8] = '{16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[9] = '{16'h1234, 16'hEDCC, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a64 = '0; b64 = '0; c_in = 1'b0;
      cur = mk(64'h0, 64'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("rst_outputs", {ov16, c16, g16, p16, s16}, 20'h0);
      @(negedge clk) rst = 1'b0;
      #1 check("rst_in_ready", rdy16, 1'b1);
      @(posedge clk); #1;

      // Single add: out_valid high for exactly one cycle, two cycles after presentation
      drive_vec(tbl[0]);
      in_valid = 1'b1;
      vbits = '0;
      for (int i = 0; i < 5; i++) begin
         tick();
         vbits[i] = ov_s;
         in_valid = 1'b0;
      end
      check("basic_valid_pattern", vbits, 5'b00100);

      // Directed table, back to back
      for (int i = 0; i < 10; i++) begin
         drive_vec(tbl[i]);
         in_valid = 1'b1;
         tick();
         check("tbl_accept", rdy_s, 1'b1);
      end
      drain(4);
      check("tbl_drain", sbq.size(), 0);

      // Backpressure: two accepted, then in_ready low and output held
      out_ready = 1'b0;
      k = 0;
      hold2 = '0; hold3 = '0;
      for (int cyc = 0; cyc < 4; cyc++) begin
         ba = 16'(4096 * (k + 1) + k);
         bb = 16'(273 * (k + 1));
         a64 = {48'h0, ba}; b64 = {48'h0, bb}; c_in = 1'b0;
         cur = model(a64, b64, 1'b0);
         in_valid = 1'b1;
         tick();
         if (rdy_s) k++;
         if (cyc == 2) hold2 = s16;
         if (cyc == 3) hold3 = s16;
      end
      check("bp_accepted", k, 2);
      check("bp_in_ready_low", rdy16, 1'b0);
      check("bp_hold_c2", hold2, 16'h1111);
      check("bp_hold_c3", hold3, 16'h1111);
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 8; cyc++) begin
         if (k < 4) begin
            ba = 16'(4096 * (k + 1) + k);
            bb = 16'(273 * (k + 1));
            a64 = {48'h0, ba}; b64 = {48'h0, bb};
            cur = model(a64, b64, 1'b0);
            in_valid = 1'b1;
         end else in_valid = 1'b0;
         tick();
         if (cyc == 0) check("simul_accept", rdy_s, 1'b1);
         if (in_valid && rdy_s) k++;
      end
      check("bp_all_sent", k, 4);
      drain(3);
      check("bp_drain", sbq.size(), 0);

      // Bubbles: out_valid mirrors in_valid two cycles later
      iv = '0; ovb = '0; expb = '0;
      for (int i = 0; i < 12; i++) begin
         iv[i] = (i < 8) && (i % 2 == 0);
         a64 = {48'h0, 16'(i * 1111)}; b64 = {48'h0, 16'(i * 77)}; c_in = i[0];
         cur = model(a64, b64, c_in);
         in_valid = iv[i];
         tick();
         ovb[i] = ov_s;
      end
      for (int i = 2; i < 12; i++) expb[i] = iv[i-2];
      check("bubble_pattern", ovb, expb);
      drain(3);

      // Random traffic with random backpressure
      in_valid = 1'b0;
      for (int n = 0; n < 10000; n++) begin
         if (!in_valid || rdy_s) begin
            a64 = {$urandom, $urandom};
            b64 = {$urandom, $urandom};
            c_in = 1'($urandom_range(1));
            cur = model(a64, b64, c_in);
            in_valid = ($urandom_range(3) != 0);
         end
         out_ready = ($urandom_range(1) != 0);
         tick();
      end
      drain(6);
      check("rand_drain", sbq.size(), 0);

      // Asynchronous reset with both stages full
      out_ready = 1'b0;
      drive_vec('{16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0});
      in_valid = 1'b1;
      tick();
      drive_vec('{16'h4444, 16'h1111, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0});
      tick();
      check("pre_rst_out", {ov16, s16}, {1'b1, 16'h3333});
      check("pre_rst_full", rdy16, 1'b0);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1 check("mid_rst_out", {ov16, c16, s16}, 18'h0);
      check("mid_rst_w64", {ov64, c64, s64}, 66'h0);
      sbq.delete();
      @(negedge clk) rst = 1'b0;
      #1 check("post_rst_in_ready", rdy16, 1'b1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      stale = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (ov_s) stale++;
      end
      check("no_stale", stale, 0);

      $display("Result: errors=%0d of %0d checks", err, chk);
      $finish;
   end

endmodule
